// File: rtl/fifo_ctrl_pkg.sv
// fifo_ctrl_pkg: shared types and constants for the FIFO control block.
//   state_e   : controller state (S_EMPTY, S_ACTIVE, S_FULL)
//   MODE_UP   : ud_counter MODE value for increment
//   MODE_DOWN : ud_counter MODE value for decrement
package fifo_ctrl_pkg;

  typedef enum logic [1:0] {
    S_EMPTY  = 2'd0,
    S_ACTIVE = 2'd1,
    S_FULL   = 2'd2
  } state_e;

  localparam logic MODE_UP   = 1'b1;
  localparam logic MODE_DOWN = 1'b0;

endpackage

// File: rtl/ud_counter.sv
// ud_counter: WIDTH-bit up/down counter, wraps modulo 2**WIDTH.
//   CLK    in  rising-edge clock
//   RST_N  in  asynchronous active-low reset, clears OUT
//   ENABLE in  1 = count this cycle, 0 = hold
//   MODE   in  1 = up, 0 = down
//   OUT    out current count
module ud_counter
  import fifo_ctrl_pkg::*;
#(
  parameter int WIDTH = 5
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             ENABLE,
  input  logic             MODE,
  output logic [WIDTH-1:0] OUT
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (ENABLE) cnt_d = (MODE == MODE_UP) ? cnt_q + WIDTH'(1) : cnt_q - WIDTH'(1);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign OUT = cnt_q;

endmodule

// File: rtl/fifo_ctrl.sv
// fifo_ctrl: FIFO control -- accept logic, EMPTY/ACTIVE/FULL FSM and three
// ud_counter instances (write pointer, read pointer, occupancy).
//   CLK, RST_N       clock, asynchronous active-low reset
//   PUSH, POP        requests, sampled at posedge CLK
//   WR_EN, RD_EN     combinational RAM enables (request accepted this cycle)
//   WR_ADDR, RD_ADDR RAM addresses (pointers)
//   USE_DW           occupancy 0..DEPTH
//   FULL, EMPTY      registered flags, decoded from the state register
//   OVF, UDF         sticky reject flags, present only when the macro
//                    FIFO_CTRL_ERR_FLAGS_EN is defined
module fifo_ctrl
  import fifo_ctrl_pkg::*;
#(
  parameter int DEPTH_LOG2 = 5
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  PUSH,
  input  logic                  POP,
  output logic                  WR_EN,
  output logic                  RD_EN,
  output logic [DEPTH_LOG2-1:0] WR_ADDR,
  output logic [DEPTH_LOG2-1:0] RD_ADDR,
  output logic [DEPTH_LOG2:0]   USE_DW,
  output logic                  FULL,
  output logic                  EMPTY
`ifdef FIFO_CTRL_ERR_FLAGS_EN
  ,
  output logic                  OVF,
  output logic                  UDF
`endif
);

  localparam logic [DEPTH_LOG2:0] DEPTH    = (DEPTH_LOG2+1)'(1) << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_M1 = DEPTH - (DEPTH_LOG2+1)'(1);

  state_e state_q;
  logic   wr_acc, rd_acc;
  logic   occ_en, occ_mode;

  // In S_FULL a push is only taken alongside a pop (RAM is read-first there).
  // Gating with RST_N keeps the enables low while reset is held.
  assign wr_acc = RST_N & PUSH & ((state_q != S_FULL) | POP);
  assign rd_acc = RST_N & POP  & (state_q != S_EMPTY);

  assign WR_EN = wr_acc;
  assign RD_EN = rd_acc;

  // Occupancy moves only when exactly one side is accepted.
  assign occ_en   = wr_acc ^ rd_acc;
  assign occ_mode = wr_acc ? MODE_UP : MODE_DOWN;

  ud_counter #(.WIDTH(DEPTH_LOG2)) u_wr_ptr (
    .CLK(CLK), .RST_N(RST_N), .ENABLE(wr_acc), .MODE(MODE_UP), .OUT(WR_ADDR)
  );

  ud_counter #(.WIDTH(DEPTH_LOG2)) u_rd_ptr (
    .CLK(CLK), .RST_N(RST_N), .ENABLE(rd_acc), .MODE(MODE_UP), .OUT(RD_ADDR)
  );

  ud_counter #(.WIDTH(DEPTH_LOG2+1)) u_occ (
    .CLK(CLK), .RST_N(RST_N), .ENABLE(occ_en), .MODE(occ_mode), .OUT(USE_DW)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_EMPTY;
    end else begin
      case (state_q)
        S_EMPTY:  if (wr_acc) state_q <= S_ACTIVE;
        S_ACTIVE: begin
          if (wr_acc && !rd_acc && USE_DW == DEPTH_M1)                  state_q <= S_FULL;
          else if (rd_acc && !wr_acc && USE_DW == (DEPTH_LOG2+1)'(1))   state_q <= S_EMPTY;
        end
        S_FULL:   if (rd_acc && !wr_acc) state_q <= S_ACTIVE;
        default:  state_q <= S_EMPTY;
      endcase
    end
  end

  assign FULL  = (state_q == S_FULL);
  assign EMPTY = (state_q == S_EMPTY);

`ifdef FIFO_CTRL_ERR_FLAGS_EN
  logic ovf_q, udf_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if (PUSH && !wr_acc) ovf_q <= 1'b1;
      if (POP  && !rd_acc) udf_q <= 1'b1;
    end
  end

  assign OVF = ovf_q;
  assign UDF = udf_q;
`endif

endmodule

// File: tb/tb_fifo_ctrl.sv
// tb_fifo_ctrl: scoreboard bench for fifo_ctrl (DEPTH_LOG2 = 5).
module tb_fifo_ctrl;

  localparam int DL2   = 5;
  localparam int DEPTH = 32;

  typedef struct {
    int unsigned cnt;
    int unsigned wp;
    int unsigned rp;
    int unsigned full;
    int unsigned empty;
    int unsigned ovf;
    int unsigned udf;
  } exp_t;

  logic           CLK = 1'b0;
  logic           RST_N, PUSH, POP;
  logic           WR_EN, RD_EN;
  logic [DL2-1:0] WR_ADDR, RD_ADDR;
  logic [DL2:0]   USE_DW;
  logic           FULL, EMPTY;
`ifdef FIFO_CTRL_ERR_FLAGS_EN
  logic           OVF, UDF;
`endif

  int checks = 0;
  int errors = 0;

  exp_t sb_q[$];

  // independent behavioural model
  int unsigned m_cnt, m_wp, m_rp, m_ovf, m_udf;

  fifo_ctrl #(.DEPTH_LOG2(DL2)) dut (
    .CLK(CLK), .RST_N(RST_N), .PUSH(PUSH), .POP(POP),
    .WR_EN(WR_EN), .RD_EN(RD_EN), .WR_ADDR(WR_ADDR), .RD_ADDR(RD_ADDR),
    .USE_DW(USE_DW), .FULL(FULL), .EMPTY(EMPTY)
`ifdef FIFO_CTRL_ERR_FLAGS_EN
    , .OVF(OVF), .UDF(UDF)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_wp = 0; m_rp = 0; m_ovf = 0; m_udf = 0;
  endtask

  task automatic chk_state(input string tag);
    chk({tag, ".use_dw"}, USE_DW,  m_cnt);
    chk({tag, ".wr_addr"}, WR_ADDR, m_wp);
    chk({tag, ".rd_addr"}, RD_ADDR, m_rp);
    chk({tag, ".full"},   FULL,    (m_cnt == DEPTH) ? 1 : 0);
    chk({tag, ".empty"},  EMPTY,   (m_cnt == 0) ? 1 : 0);
`ifdef FIFO_CTRL_ERR_FLAGS_EN
    chk({tag, ".ovf"}, OVF, m_ovf);
    chk({tag, ".udf"}, UDF, m_udf);
`endif
  endtask

  // One clock of stimulus: check the combinational enables, queue the
  // post-edge expectation, then compare after the edge.
  task automatic cycle(input string tag, input logic p, input logic q);
    bit   wa, ra;
    exp_t e, got;
    @(negedge CLK);
    PUSH = p; POP = q;
    #1;
    wa = p && ((m_cnt != DEPTH) || q);
    ra = q && (m_cnt != 0);
    chk({tag, ".wr_en"}, WR_EN, wa);
    chk({tag, ".rd_en"}, RD_EN, ra);
    if (p && !wa) m_ovf = 1;
    if (q && !ra) m_udf = 1;
    if (wa) m_wp = (m_wp + 1) % DEPTH;
    if (ra) m_rp = (m_rp + 1) % DEPTH;
    if (wa && !ra) m_cnt++;
    if (ra && !wa) m_cnt--;
    e.cnt = m_cnt; e.wp = m_wp; e.rp = m_rp;
    e.full = (m_cnt == DEPTH) ? 1 : 0; e.empty = (m_cnt == 0) ? 1 : 0;
    e.ovf = m_ovf; e.udf = m_udf;
    sb_q.push_back(e);
    @(posedge CLK);
    #1;
    if (sb_q.size() == 0) begin
      chk({tag, ".sb_empty"}, 0, 1);
    end else begin
      got = sb_q.pop_front();
      chk({tag, ".use_dw"}, USE_DW,  got.cnt);
      chk({tag, ".wr_addr"}, WR_ADDR, got.wp);
      chk({tag, ".rd_addr"}, RD_ADDR, got.rp);
      chk({tag, ".full"},   FULL,    got.full);
      chk({tag, ".empty"},  EMPTY,   got.empty);
`ifdef FIFO_CTRL_ERR_FLAGS_EN
      chk({tag, ".ovf"}, OVF, got.ovf);
      chk({tag, ".udf"}, UDF, got.udf);
`endif
    end
  endtask

  initial begin
    PUSH = 1'b0; POP = 1'b0; RST_N = 1'b0;
    model_reset();
    #1;
    chk_state("rst_low");
    chk("rst_low.wr_en", WR_EN, 0);
    #1 RST_N = 1'b1;
    #1;
    chk_state("rst");

    // fill, then overflow attempt
    for (int i = 0; i < DEPTH; i++) cycle("fill", 1'b1, 1'b0);
    chk("fill.use_dw32", USE_DW, 32);
    chk("fill.wr_wrap", WR_ADDR, 0);
    cycle("ovf", 1'b1, 1'b0);

    // full with push+pop: both taken, stays full
    cycle("full_both", 1'b1, 1'b1);
    chk("full_both.full", FULL, 1);

    // drain, then underflow attempt
    for (int i = 0; i < DEPTH; i++) cycle("drain", 1'b0, 1'b1);
    chk("drain.empty", EMPTY, 1);
    cycle("udf", 1'b0, 1'b1);

    // empty with push+pop: pop ignored
    cycle("empty_both", 1'b1, 1'b1);
    chk("empty_both.use_dw", USE_DW, 1);

    // reach 5, then simultaneous push+pop for 3 cycles
    for (int i = 0; i < 4; i++) cycle("to5", 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cycle("simul", 1'b1, 1'b1);
    chk("simul.use_dw", USE_DW, 5);

    // random mix
    for (int i = 0; i < 200; i++)
      cycle("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

    // settle at 17 then reset between edges
    while (m_cnt > 17) cycle("to17", 1'b0, 1'b1);
    while (m_cnt < 17) cycle("to17", 1'b1, 1'b0);
    chk("pre_rst.use_dw", USE_DW, 17);
    @(negedge CLK);
    PUSH = 1'b1; POP = 1'b1;
    #2 RST_N = 1'b0;
    model_reset();
    #1;
    chk_state("mid_rst");
    chk("mid_rst.wr_en", WR_EN, 0);
    chk("mid_rst.rd_en", RD_EN, 0);
    PUSH = 1'b0; POP = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
    cycle("post_rst", 1'b1, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_ctrl.md
# fifo_ctrl

Control block for the FIFO: sequences the read pointer, write pointer and occupancy up/down counters from PUSH/POP requests and derives FULL/EMPTY. It sits between the FIFO's external handshake and the dual-port RAM, supplying RAM addresses and write/read enables. The counters are instances of one small up/down counter sub-module with ENABLE/MODE control (MODE=1 up, MODE=0 down).

## Interface
- DEPTH_LOG2, 5, log2 of FIFO depth; DEPTH = 2**DEPTH_LOG2 (default 32 entries); legal range 1..10
- CLK  in  1  rising-edge clock
- RST_N  in  1  asynchronous, active-low reset
- PUSH  in  1  write request, sampled at posedge CLK
- POP  in  1  read request, sampled at posedge CLK
- WR_EN  out  1  RAM write enable; combinational, PUSH accepted this cycle
- RD_EN  out  1  RAM read enable; combinational, POP accepted this cycle
- WR_ADDR  out  DEPTH_LOG2  write pointer (RAM write address)
- RD_ADDR  out  DEPTH_LOG2  read pointer (RAM read address)
- USE_DW  out  DEPTH_LOG2+1  occupancy, 0..DEPTH
- FULL  out  1  registered, USE_DW == DEPTH
- EMPTY  out  1  registered, USE_DW == 0

## Operation
- FSM states: S_EMPTY, S_ACTIVE, S_FULL. FULL/EMPTY decode directly from the state register.
- Accept rules: push accepted when PUSH and not S_FULL, or PUSH and POP in S_FULL. Pop accepted when POP and not S_EMPTY.
- Accepted push: write-pointer counter ENABLE=1, MODE=up. Accepted pop: read-pointer counter ENABLE=1, MODE=up.
- Occupancy counter:
  - push only: ENABLE=1, MODE=up
  - pop only: ENABLE=1, MODE=down
  - both or neither: ENABLE=0
- Transitions:
  - S_EMPTY + push: to S_ACTIVE. POP in the same cycle is ignored.
  - S_ACTIVE + push only with USE_DW==DEPTH-1: to S_FULL.
  - S_ACTIVE + pop only with USE_DW==1: to S_EMPTY.
  - S_ACTIVE + both: stay in S_ACTIVE.
  - S_FULL + pop only: to S_ACTIVE.
  - S_FULL + both: stay in S_FULL. RAM must be read-first at the shared address.
  - Otherwise hold state.
- Pointer arithmetic is unsigned modulo DEPTH. Wrap from DEPTH-1 to 0 is natural counter rollover, with no special case.
- Rejected requests (push when full, pop when empty) change nothing: no enable, no pointer move.

## Timing
- Reset (RST_N low, asynchronous): WR_ADDR=0, RD_ADDR=0, USE_DW=0, state S_EMPTY, EMPTY=1, FULL=0. While reset is asserted, WR_EN=0 and RD_EN=0.
- Reset mid-operation discards all contents immediately. The first posedge after RST_N rises behaves as from an empty FIFO.
- Latency: WR_EN/RD_EN assert in the same cycle as the request (combinational). Pointers, USE_DW and flags update at the posedge that samples the accepted request.
- A push to an empty FIFO makes the data readable from the next cycle (EMPTY falls one cycle after the request).

## Configuration
- FIFO_CTRL_ERR_FLAGS_EN defined: adds outputs OVF and UDF (1 bit each), sticky, registered.
  - OVF sets at the posedge where a push is rejected.
  - UDF sets at the posedge where a pop is rejected.
  - Both cleared only by RST_N (reset value 0).
- FIFO_CTRL_ERR_FLAGS_EN undefined: the ports are absent and rejected requests are silently dropped.

## Structure
- Package fifo_ctrl_pkg holds:
  - state typedef, enum {S_EMPTY, S_ACTIVE, S_FULL}
  - MODE_UP=1'b1 and MODE_DOWN=1'b0 constants
- Sub-module ud_counter, parameter WIDTH, ports CLK, RST_N, ENABLE, MODE, OUT. It resets OUT to 0, holds when ENABLE=0, and adds/subtracts 1 mod 2**WIDTH.
- fifo_ctrl instantiates ud_counter three times: two at DEPTH_LOG2 bits, one at DEPTH_LOG2+1 bits. It contains only the accept logic and the FSM.

## Test plan
All scenarios use DEPTH_LOG2=5.
- Reset: RST_N low for 1 ns, then high -> EMPTY=1, FULL=0, USE_DW=0, WR_ADDR=0, RD_ADDR=0.
- Fill: 32 consecutive PUSH cycles -> USE_DW=32, FULL=1 after the 32nd posedge, WR_ADDR=0 (wrapped). A 33rd PUSH -> WR_EN=0, state unchanged, OVF=1 if the macro is enabled.
- Drain: from full, 32 POP cycles -> USE_DW=0, EMPTY=1, RD_ADDR=0. A further POP -> RD_EN=0, UDF=1 if the macro is enabled.
- Simultaneous: USE_DW=5, PUSH+POP for 3 cycles -> USE_DW stays 5, WR_ADDR and RD_ADDR each advance by 3.
- Boundaries:
  - Empty with PUSH+POP -> RD_EN=0, WR_EN=1, USE_DW=1.
  - Full with PUSH+POP -> both enables 1, FULL stays 1.
- Reset mid-operation: USE_DW=17, assert RST_N low between edges -> all outputs return to reset values immediately, without waiting for CLK.
